// File: rtl/sigmoid_lut_loader.sv
// Sigmoid LUT load-port writer: assembles little-endian 16-bit words from a host byte stream.
// Optional trailing checksum enabled by defining SIGMOID_LUT_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start after reset
// LO      | accepting low byte of the next table word
// HI      | accepting high byte; word is formed on transfer
// WRITE   | one-cycle lut_we strobe, sum and address update
// CSUM_LO | accepting low byte of the host checksum
// CSUM_HI | accepting high byte; checksum compared on transfer
// DONE    | load complete, waiting for the next start
module sigmoid_lut_loader #(
   parameter int N_ENTRIES = 121,
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              lut_we,
   output logic [ADDR_W-1:0] lut_addr,
   output logic [DATA_W-1:0] lut_d,
   output logic              busy,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LO      = 3'd1;
   localparam logic [2:0] S_HI      = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
`ifdef SIGMOID_LUT_CHECKSUM_EN
   localparam logic [2:0] S_CSUM_LO = 3'd5;
   localparam logic [2:0] S_CSUM_HI = 3'd6;
`endif

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ENTRIES - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        lo_q, lo_d;
   logic [DATA_W-1:0] d_q, d_d;
   logic              xfer;

   assign xfer = byte_valid && byte_ready;

`ifdef SIGMOID_LUT_CHECKSUM_EN
   logic [15:0] sum_q, sum_d;
   logic        err_q, err_d;

   assign byte_ready = (state_q == S_LO) || (state_q == S_HI) ||
                       (state_q == S_CSUM_LO) || (state_q == S_CSUM_HI);
   assign load_err   = err_q;
`else
   assign byte_ready = (state_q == S_LO) || (state_q == S_HI);
   assign load_err   = 1'b0;
`endif

   assign lut_we    = (state_q == S_WRITE);
   assign lut_addr  = addr_q;
   assign lut_d     = d_q;
   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   // DONE is left only through start, so the state itself is the sticky done flag.
   assign load_done = (state_q == S_DONE);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lo_d    = lo_q;
      d_d     = d_q;
`ifdef SIGMOID_LUT_CHECKSUM_EN
      sum_d   = sum_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LO;
               addr_d  = '0;
`ifdef SIGMOID_LUT_CHECKSUM_EN
               sum_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         S_LO: begin
            if (xfer) begin
               lo_d    = byte_in;
               state_d = S_HI;
            end
         end
         S_HI: begin
            if (xfer) begin
               d_d     = {byte_in, lo_q};
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
`ifdef SIGMOID_LUT_CHECKSUM_EN
            sum_d = sum_q + d_q;
`endif
            if (addr_q == LAST_ADDR) begin
`ifdef SIGMOID_LUT_CHECKSUM_EN
               state_d = S_CSUM_LO;
`else
               state_d = S_DONE;
`endif
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_LO;
            end
         end
`ifdef SIGMOID_LUT_CHECKSUM_EN
         S_CSUM_LO: begin
            if (xfer) begin
               lo_d    = byte_in;
               state_d = S_CSUM_HI;
            end
         end
         S_CSUM_HI: begin
            if (xfer) begin
               err_d   = ({byte_in, lo_q} != sum_q);
               state_d = S_DONE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         lo_q    <= '0;
         d_q     <= '0;
`ifdef SIGMOID_LUT_CHECKSUM_EN
         sum_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lo_q    <= lo_d;
         d_q     <= d_d;
`ifdef SIGMOID_LUT_CHECKSUM_EN
         sum_q   <= sum_d;
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_sigmoid_lut_loader.sv
// Self-checking bench for sigmoid_lut_loader: table-driven loads plus hand-written corner sequences.
// Follows SIGMOID_LUT_CHECKSUM_EN the same way as the design.
module tb_sigmoid_lut_loader;

   localparam int N = 121;
`ifdef SIGMOID_LUT_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready, lut_we, busy, load_done, load_err;
   logic [6:0]  lut_addr;
   logic [15:0] lut_d;

   sigmoid_lut_loader #(.N_ENTRIES(N), .ADDR_W(7), .DATA_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .lut_we(lut_we),
      .lut_addr(lut_addr), .lut_d(lut_d), .busy(busy),
      .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;
   int start_cyc = 0;
   int ready_during_we = 0;

   logic [15:0] exp_words [N];
   int          wr_a[$];
   logic [15:0] wr_d[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (lut_we) begin
         wr_a.push_back(int'(lut_addr));
         wr_d.push_back(lut_d);
         if (byte_ready) ready_during_we++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [15:0] model_sum();
      int s = 0;
      for (int i = 0; i < N; i++) s += int'(exp_words[i]);
      return 16'(s);
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      start_cyc = cyc;
   endtask

   // gap: 0 continuous, 1 valid toggles every other cycle, 2 random idle cycles
   task automatic send_byte(input logic [7:0] b, input int gap);
      int budget = 20;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
         byte_valid = 1'b0;
         byte_in    = 8'($urandom);
         @(posedge clk); #1;
      end
      byte_in    = b;
      byte_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (byte_ready) break;
         budget--;
         if (budget == 0) break;
      end
      if (budget == 0) check("byte_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic run_load(input string nm, input int gap, input logic [15:0] csum,
                           input logic exp_err, input int ign_at, input bit chk_cycles);
      int bad = 0;
      int budget = 20;
      wr_a.delete();
      wr_d.delete();
      pulse_start();
      check({nm, "_start_clears"}, {29'd0, busy, load_done, load_err}, 32'b100);
      for (int k = 0; k < N; k++) begin
         send_byte(exp_words[k][7:0], gap);
         if (k == ign_at) start = 1'b1;
         send_byte(exp_words[k][15:8], gap);
         if (k == ign_at) begin
            start = 1'b0;
            check({nm, "_ign_start_addr"}, {24'd0, lut_we, lut_addr}, {24'd0, 1'b1, 7'(k)});
         end
      end
      if (CS) begin
         send_byte(csum[7:0], gap);
         send_byte(csum[15:8], gap);
         check({nm, "_done_after_csum"}, {31'd0, load_done}, 32'd1);
      end
      while (!load_done && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      if (chk_cycles)
         check({nm, "_cycles"}, 32'(cyc - start_cyc), 32'(3 * N + (CS ? 2 : 0)));
      check({nm, "_done"}, {31'd0, load_done}, 32'd1);
      check({nm, "_err"}, {31'd0, load_err}, {31'd0, exp_err & CS});
      check({nm, "_idle_outs"}, {30'd0, busy, byte_ready}, 32'd0);
      check({nm, "_we_count"}, 32'(wr_a.size()), 32'(N));
      for (int i = 0; i < wr_a.size() && i < N; i++)
         if (wr_a[i] != i || wr_d[i] !== exp_words[i]) bad++;
      check({nm, "_writes"}, 32'(bad), 32'd0);
   endtask

   typedef struct {
      bit          rnd;
      logic [15:0] word;
      logic [15:0] csum;
      logic [15:0] adj;
      int          gap;
      logic        exp_err;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{rnd: 1'b0, word: 16'h0080, csum: 16'h3C80, adj: 16'h0000, gap: 0, exp_err: 1'b0};
      vecs[1] = '{rnd: 1'b0, word: 16'h0080, csum: 16'h3C81, adj: 16'h0000, gap: 0, exp_err: 1'b1};
      vecs[2] = '{rnd: 1'b1, word: 16'h0000, csum: 16'h0000, adj: 16'h0000, gap: 2, exp_err: 1'b0};
      vecs[3] = '{rnd: 1'b1, word: 16'h0000, csum: 16'h0000, adj: 16'h0100, gap: 2, exp_err: 1'b1};
      vecs[4] = '{rnd: 1'b0, word: 16'hFFFF, csum: 16'hFF87, adj: 16'h0000, gap: 0, exp_err: 1'b0};

      #12;
      check("reset_outs", {6'd0, byte_ready, lut_we, lut_addr, lut_d, busy, load_done, load_err}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // no activity without start, even with bytes offered
      wr_a.delete();
      for (int i = 0; i < 10; i++) begin
         byte_valid = 1'($urandom);
         byte_in    = 8'($urandom);
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      check("no_we_without_start", 32'(wr_a.size()), 32'd0);
      check("idle_not_ready", {30'd0, busy, byte_ready}, 32'd0);

      for (int v = 0; v < 5; v++) begin
         logic [15:0] cs;
         for (int i = 0; i < N; i++)
            exp_words[i] = vecs[v].rnd ? 16'($urandom) : vecs[v].word;
         cs = vecs[v].rnd ? model_sum() + vecs[v].adj : vecs[v].csum;
         run_load($sformatf("vec%0d", v), vecs[v].gap, cs, vecs[v].exp_err, -1, vecs[v].gap == 0);
      end

      // backpressure with a single 0x8000 word at address 5
      for (int i = 0; i < N; i++) exp_words[i] = 16'(i + 1);
      exp_words[5] = 16'h8000;
      run_load("bp", 1, model_sum(), 1'b0, -1, 1'b0);
      begin
         int hits = 0;
         int at = -1;
         for (int i = 0; i < wr_d.size(); i++)
            if (wr_d[i] == 16'h8000) begin hits++; at = wr_a[i]; end
         check("bp_8000_count", 32'(hits), 32'd1);
         check("bp_8000_addr", 32'(at), 32'd5);
      end

      // start pulsed in HI at address 10 is ignored
      for (int i = 0; i < N; i++) exp_words[i] = 16'($urandom);
      run_load("ign", 0, model_sum(), 1'b0, 10, 1'b1);

      // reload from DONE after a bad-checksum load
      for (int i = 0; i < N; i++) exp_words[i] = 16'h1234;
      run_load("bad_pre", 0, model_sum() ^ 16'h0001, 1'b1, -1, 1'b0);
      for (int i = 0; i < N; i++) exp_words[i] = 16'(3 * i);
      run_load("reload", 0, model_sum(), 1'b0, -1, 1'b0);
      check("reload_first_addr", 32'(wr_a.size() > 0 ? wr_a[0] : -1), 32'd0);

      // reset while in HI of entry 1 clears every output at once
      for (int i = 0; i < N; i++) exp_words[i] = 16'hA5C3;
      pulse_start();
      send_byte(8'hC3, 0);
      send_byte(8'hA5, 0);
      send_byte(8'hC3, 0);
      check("mid_hi_state", {24'd0, byte_ready, lut_addr}, {24'd0, 1'b1, 7'd1});
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_outs", {6'd0, byte_ready, lut_we, lut_addr, lut_d, busy, load_done, load_err}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      wr_a.delete();
      for (int i = 0; i < 20; i++) begin
         byte_valid = 1'($urandom);
         byte_in    = 8'($urandom);
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      check("post_reset_no_we", 32'(wr_a.size()), 32'd0);
      check("post_reset_idle", {29'd0, busy, load_done, byte_ready}, 32'd0);
      check("ready_never_with_we", 32'(ready_during_we), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
